cache_fill_controller: RTL and testbench

- Direct-mapped, read-only cache controller that sits directly upstream of the cache address mux.
- Performs tag/valid lookup for processor accesses and stalls the processor on a miss.
- On a miss, fetches the whole line from main memory word by word and writes it into the cache data RAM.
- Drives the mux select and FSM address during the fill; the processor address path is selected at all other times.

---
 rtl/cache_fill_controller_if.sv | 32 +++
 rtl/cache_fill_controller.sv | 122 ++++++++++++
 tb/tb_cache_fill_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_controller_if.sv
// Handshake bundle between the cache fill controller, the processor, main memory and
// the cache RAM address/write path.
interface cache_fill_controller_if #(
  parameter int unsigned ADDRESS_WIDTH  = 10,
  parameter int unsigned MEM_ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH     = 8
);
  logic                      proc_req;
  logic [MEM_ADDR_WIDTH-1:0] proc_mem_addr;
  logic                      proc_stall;
  logic                      mem_rd_req;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic                      mem_rd_valid;
  logic [DATA_WIDTH-1:0]     mem_rd_data;
  logic                      cache_sel;
  logic [ADDRESS_WIDTH-1:0]  cache_fsm_addr;
  logic                      cache_wr_en;
  logic [DATA_WIDTH-1:0]     cache_wr_data;
  logic                      fill_done;

  modport master (
    input  proc_req, proc_mem_addr, mem_rd_valid, mem_rd_data,
    output proc_stall, mem_rd_req, mem_addr, cache_sel, cache_fsm_addr, cache_wr_en,
           cache_wr_data, fill_done
  );

  modport slave (
    output proc_req, proc_mem_addr, mem_rd_valid, mem_rd_data,
    input  proc_stall, mem_rd_req, mem_addr, cache_sel, cache_fsm_addr, cache_wr_en,
           cache_wr_data, fill_done
  );
endinterface

// File: rtl/cache_fill_controller.sv
// Direct-mapped read-only cache controller: tag/valid lookup, processor stall on miss,
// and a word-by-word line fill from main memory into the cache data RAM.
module cache_fill_controller #(
  parameter int unsigned ADDRESS_WIDTH  = 10,
  parameter int unsigned MEM_ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned OFFSET_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  cache_fill_controller_if.master bus
);
  localparam int unsigned IndexWidth = ADDRESS_WIDTH - OFFSET_WIDTH;
  localparam int unsigned TagWidth   = MEM_ADDR_WIDTH - ADDRESS_WIDTH;
  localparam int unsigned NumLines   = 2 ** IndexWidth;

  typedef enum logic [1:0] {StIdle, StReq, StWrite, StDone} state_e;

  state_e                  state_q, state_d;
  logic [TagWidth-1:0]     tag_q, tag_d;
  logic [IndexWidth-1:0]   index_q, index_d;
  logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [NumLines-1:0]     valid_q;
  logic [TagWidth-1:0]     tags_q [NumLines];
  logic                    line_done;

  logic [TagWidth-1:0]   proc_tag;
  logic [IndexWidth-1:0] proc_index;
  logic                  hit;

  assign proc_tag   = bus.proc_mem_addr[MEM_ADDR_WIDTH-1:ADDRESS_WIDTH];
  assign proc_index = bus.proc_mem_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
  assign hit        = valid_q[proc_index] && (tags_q[proc_index] == proc_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tag_q   <= '0;
      index_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      if (line_done) begin
        valid_q[index_q] <= 1'b1;
      end
    end
  end

  // Tag storage is deliberately not reset; the valid bits alone gate a hit.
  always_ff @(posedge clk) begin
    if (line_done) begin
      tags_q[index_q] <= tag_q;
    end
  end

  always_comb begin
    state_d            = state_q;
    tag_d              = tag_q;
    index_d            = index_q;
    cnt_d              = cnt_q;
    data_d             = data_q;
    line_done          = 1'b0;
    bus.proc_stall     = 1'b0;
    bus.mem_rd_req     = 1'b0;
    bus.mem_addr       = '0;
    bus.cache_sel      = 1'b0;
    bus.cache_fsm_addr = '0;
    bus.cache_wr_en    = 1'b0;
    bus.cache_wr_data  = '0;
    bus.fill_done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Stall is combinational on the lookup; masked so outputs read 0 while in reset.
        bus.proc_stall = bus.proc_req && !hit && !rst;
        if (bus.proc_req && !hit) begin
          tag_d   = proc_tag;
          index_d = proc_index;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        bus.cache_sel  = 1'b1;
        bus.proc_stall = 1'b1;
        bus.mem_rd_req = 1'b1;
        bus.mem_addr   = {tag_q, index_q, cnt_q};
        if (bus.mem_rd_valid) begin
          data_d  = bus.mem_rd_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        bus.cache_sel      = 1'b1;
        bus.proc_stall     = 1'b1;
        bus.cache_wr_en    = 1'b1;
        bus.cache_fsm_addr = {index_q, cnt_q};
        bus.cache_wr_data  = data_q;
        if (&cnt_q) begin
          line_done = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d   = cnt_q + OFFSET_WIDTH'(1);
          state_d = StReq;
        end
      end
      StDone: begin
        bus.proc_stall = 1'b1;
        bus.fill_done  = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end
endmodule

// File: tb/tb_cache_fill_controller.sv
// Bench for cache_fill_controller: a queue-based fill model checked every cycle, plus
// directed accesses with hand-computed addresses, data and latencies.
module tb_cache_fill_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  cache_fill_controller_if #(.ADDRESS_WIDTH(10), .MEM_ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  cache_fill_controller #(
    .ADDRESS_WIDTH (10),
    .MEM_ADDR_WIDTH(16),
    .DATA_WIDTH    (8),
    .OFFSET_WIDTH  (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: each word holds the low address byte XOR 0x5A.
  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  int   wait_cfg = 0;
  int   wait_cnt = 0;
  logic stray = 1'b0;
  assign bus.mem_rd_valid = (bus.mem_rd_req && (wait_cnt >= wait_cfg)) || stray;
  assign bus.mem_rd_data  = mem_fn(bus.mem_addr);
  always @(posedge clk) begin
    if (bus.mem_rd_req && !bus.mem_rd_valid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: cache contents plus a script of pending fill steps (fetch word, write word, done).
  typedef struct {
    int          kind;  // 0 fetch, 1 write, 2 done
    logic [15:0] addr;
  } step_t;
  step_t      script[$];
  bit         m_valid[256];
  logic [5:0] m_tag[256];

  always @(negedge clk) begin
    logic        e_stall, e_mreq, e_sel, e_wen, e_done;
    logic [15:0] e_maddr;
    logic [9:0]  e_faddr;
    logic [7:0]  e_wdata;
    logic [15:0] a;
    e_stall = 0; e_mreq = 0; e_sel = 0; e_wen = 0; e_done = 0;
    e_maddr = '0; e_faddr = '0; e_wdata = '0;
    if (rst) begin
      script.delete();
      for (int i = 0; i < 256; i++) m_valid[i] = 0;
    end else if (script.size() == 0) begin
      a = bus.proc_mem_addr;
      if (bus.proc_req && !(m_valid[a[9:2]] && m_tag[a[9:2]] == a[15:10])) begin
        e_stall = 1;
        for (int w = 0; w < 4; w++) begin
          script.push_back('{0, {a[15:2], 2'(w)}});
          script.push_back('{1, {a[15:2], 2'(w)}});
        end
        script.push_back('{2, 16'h0});
      end
    end else begin
      a = script[0].addr;
      e_stall = 1;
      case (script[0].kind)
        0: begin
          e_sel = 1; e_mreq = 1; e_maddr = a;
          if (bus.mem_rd_valid) void'(script.pop_front());
        end
        1: begin
          e_sel = 1; e_wen = 1; e_faddr = a[9:0]; e_wdata = mem_fn(a);
          if (a[1:0] == 2'd3) begin
            m_valid[a[9:2]] = 1;
            m_tag[a[9:2]]   = a[15:10];
          end
          void'(script.pop_front());
        end
        default: begin
          e_done = 1;
          void'(script.pop_front());
        end
      endcase
    end
    chk("proc_stall", 32'(bus.proc_stall), 32'(e_stall));
    chk("mem_rd_req", 32'(bus.mem_rd_req), 32'(e_mreq));
    chk("mem_addr", 32'(bus.mem_addr), 32'(e_maddr));
    chk("cache_sel", 32'(bus.cache_sel), 32'(e_sel));
    chk("cache_wr_en", 32'(bus.cache_wr_en), 32'(e_wen));
    chk("cache_fsm_addr", 32'(bus.cache_fsm_addr), 32'(e_faddr));
    chk("cache_wr_data", 32'(bus.cache_wr_data), 32'(e_wdata));
    chk("fill_done", 32'(bus.fill_done), 32'(e_done));
  end

  logic [15:0] fetch_log[$];
  logic [9:0]  wa_log[$];
  logic [7:0]  wd_log[$];
  int          done_cyc = -1;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_rd_req && bus.mem_rd_valid) fetch_log.push_back(bus.mem_addr);
      if (bus.cache_wr_en) begin
        wa_log.push_back(bus.cache_fsm_addr);
        wd_log.push_back(bus.cache_wr_data);
      end
      if (bus.fill_done) done_cyc = cyc;
    end
  end

  task automatic access(input logic [15:0] a, output int t0, output int t_low);
    fetch_log.delete(); wa_log.delete(); wd_log.delete(); done_cyc = -1;
    @(posedge clk); #1;
    bus.proc_req = 1'b1; bus.proc_mem_addr = a; t0 = cyc;
    t_low = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.proc_stall) begin
        t_low = cyc;
        break;
      end
    end
    if (t_low < 0) chk("stall_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.proc_req = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_stall"}, 32'(bus.proc_stall), 32'd0);
    chk({tag, "_sel"}, 32'(bus.cache_sel), 32'd0);
    chk({tag, "_mreq"}, 32'(bus.mem_rd_req), 32'd0);
    chk({tag, "_maddr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_wen"}, 32'(bus.cache_wr_en), 32'd0);
    chk({tag, "_done"}, 32'(bus.fill_done), 32'd0);
  endtask

  initial begin
    int t0, tl, nw;
    bus.proc_req = 1'b1; bus.proc_mem_addr = 16'h0123;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    bus.proc_req = 1'b0; rst = 1'b0;

    // Cold miss on 0x0123: words 0x0120..0x0123, fill_done at +9, stall low at +10.
    access(16'h0123, t0, tl);
    chk("cold_latency", 32'(tl - t0), 32'd10);
    chk("cold_done_cyc", 32'(done_cyc - t0), 32'd9);
    chk("cold_nfetch", 32'(fetch_log.size()), 32'd4);
    if (fetch_log.size() == 4) begin
      chk("cold_fetch0", 32'(fetch_log[0]), 32'h0120);
      chk("cold_fetch3", 32'(fetch_log[3]), 32'h0123);
    end
    chk("cold_nwrite", 32'(wa_log.size()), 32'd4);
    if (wa_log.size() == 4) begin
      chk("cold_waddr0", 32'(wa_log[0]), 32'h120);
      chk("cold_waddr3", 32'(wa_log[3]), 32'h123);
      chk("cold_wdata0", 32'(wd_log[0]), 32'h7A);
      chk("cold_wdata1", 32'(wd_log[1]), 32'h7B);
      chk("cold_wdata2", 32'(wd_log[2]), 32'h78);
      chk("cold_wdata3", 32'(wd_log[3]), 32'h79);
    end

    // Hit on the filled line: no stall, no memory traffic.
    access(16'h0121, t0, tl);
    chk("hit_latency", 32'(tl - t0), 32'd0);
    chk("hit_nfetch", 32'(fetch_log.size()), 32'd0);

    // Conflict miss: same index, tag 1, then the old tag misses again.
    access(16'h0523, t0, tl);
    chk("conf_latency", 32'(tl - t0), 32'd10);
    if (fetch_log.size() == 4) begin
      chk("conf_fetch0", 32'(fetch_log[0]), 32'h0520);
      chk("conf_fetch3", 32'(fetch_log[3]), 32'h0523);
    end else chk("conf_nfetch", 32'(fetch_log.size()), 32'd4);
    access(16'h0121, t0, tl);
    chk("reconf_latency", 32'(tl - t0), 32'd10);
    if (fetch_log.size() > 0) chk("reconf_fetch0", 32'(fetch_log[0]), 32'h0120);
    else chk("reconf_nfetch", 32'(fetch_log.size()), 32'd4);

    // Three wait cycles per word add 12 cycles.
    wait_cfg = 3;
    access(16'h0344, t0, tl);
    chk("wait_latency", 32'(tl - t0), 32'd22);
    chk("wait_done_cyc", 32'(done_cyc - t0), 32'd21);
    if (fetch_log.size() > 0) chk("wait_fetch0", 32'(fetch_log[0]), 32'h0344);
    wait_cfg = 0;

    // Stray memory valid while idle.
    @(posedge clk); #1; stray = 1'b1;
    @(negedge clk);
    chk("stray_wen", 32'(bus.cache_wr_en), 32'd0);
    @(posedge clk); #1; stray = 1'b0;
    @(negedge clk);
    chk("stray_wen_next", 32'(bus.cache_wr_en), 32'd0);
    chk("stray_mreq_next", 32'(bus.mem_rd_req), 32'd0);

    // Reset after two words of a fill; the line must stay invalid.
    @(posedge clk); #1;
    bus.proc_req = 1'b1; bus.proc_mem_addr = 16'h0923;
    nw = 0;
    for (int i = 0; i < 100 && nw < 2; i++) begin
      @(negedge clk);
      if (bus.cache_wr_en) nw++;
    end
    chk("midfill_writes", 32'(nw), 32'd2);
    @(posedge clk); #3; rst = 1'b1;
    #1 chk_zero_outputs("midrst");
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0; bus.proc_req = 1'b0;
    access(16'h0123, t0, tl);
    chk("postrst_latency", 32'(tl - t0), 32'd10);
    if (fetch_log.size() > 0) chk("postrst_fetch0", 32'(fetch_log[0]), 32'h0120);
    else chk("postrst_nfetch", 32'(fetch_log.size()), 32'd4);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
